// File: rtl/boolean_pkg.sv
// Shared constants and types for the boolean 3-input function unit.
// Holds the default truth table (F = B & (~A | C)) and the default counter width.
package boolean_pkg;

  localparam logic [7:0] DEFAULT_TRUTH_TABLE = 8'h8C;
  localparam int         DEFAULT_CNT_W       = 8;

  typedef logic [2:0] lut_idx_t;

  // A is the most significant bit of the table index.
  function automatic lut_idx_t pack_idx(input logic a, input logic b, input logic c);
    return {a, b, c};
  endfunction

endpackage

// File: rtl/boolean_if.sv
// Signal bundle between a boolean unit (slave) and its user (master).
// toggle_cnt exists only when BOOLEAN_TOGGLE_CNT_EN is defined.
interface boolean_if
  import boolean_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) ();

  logic A;
  logic B;
  logic C;
  logic F;
  logic F_q;
  logic F_rise;

`ifdef BOOLEAN_TOGGLE_CNT_EN
  logic [CNT_W-1:0] toggle_cnt;

  modport master (output A, B, C, input  F, F_q, F_rise, toggle_cnt);
  modport slave  (input  A, B, C, output F, F_q, F_rise, toggle_cnt);
`else
  modport master (output A, B, C, input  F, F_q, F_rise);
  modport slave  (input  A, B, C, output F, F_q, F_rise);

  // CNT_W only sizes the counter; a non-positive width is never meaningful.
  if (CNT_W < 1) begin : g_invalid_cnt_w
  end
`endif

endinterface

// File: rtl/boolean_lut3.sv
// Combinational 8-entry lookup: o_f = TRUTH_TABLE[{i_a, i_b, i_c}].
// An unknown index falls to the default branch so X reaches the output unmasked.
module boolean_lut3
  import boolean_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE
) (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_f
);

  lut_idx_t w_idx;

  assign w_idx = pack_idx(i_a, i_b, i_c);

  // Table lookup
  always_comb begin
    o_f = 1'bx;
    case (w_idx)
      3'd0:    o_f = TRUTH_TABLE[0];
      3'd1:    o_f = TRUTH_TABLE[1];
      3'd2:    o_f = TRUTH_TABLE[2];
      3'd3:    o_f = TRUTH_TABLE[3];
      3'd4:    o_f = TRUTH_TABLE[4];
      3'd5:    o_f = TRUTH_TABLE[5];
      3'd6:    o_f = TRUTH_TABLE[6];
      3'd7:    o_f = TRUTH_TABLE[7];
      default: o_f = 1'bx;
    endcase
  end

endmodule

// File: rtl/boolean.sv
// Boolean function unit: combinational F, registered F_q and rising-edge pulse F_rise.
// Define BOOLEAN_TOGGLE_CNT_EN to add a wrapping count of F_q transitions (toggle_cnt).
module boolean
  import boolean_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE,
  parameter int         CNT_W       = DEFAULT_CNT_W
) (
  input logic     clk,
  input logic     reset,
  boolean_if.slave bus
);

  logic w_f;
  logic r_f_q;
  logic r_f_rise;

  boolean_lut3 #(
    .TRUTH_TABLE (TRUTH_TABLE)
  ) u_lut3 (
    .i_a (bus.A),
    .i_b (bus.B),
    .i_c (bus.C),
    .o_f (w_f)
  );

  // Registered copy of F and its 0->1 edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f_q    <= 1'b0;
      r_f_rise <= 1'b0;
    end else begin
      r_f_q    <= w_f;
      r_f_rise <= w_f & ~r_f_q;
    end
  end

  assign bus.F      = w_f;
  assign bus.F_q    = r_f_q;
  assign bus.F_rise = r_f_rise;

`ifdef BOOLEAN_TOGGLE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_toggle_cnt;

  // Count edges where F_q is about to change; wraps silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_toggle_cnt <= {CNT_W{1'b0}};
    end else if (w_f != r_f_q) begin
      r_toggle_cnt <= r_toggle_cnt + CNT_ONE;
    end else begin
      r_toggle_cnt <= r_toggle_cnt;
    end
  end

  assign bus.toggle_cnt = r_toggle_cnt;
`else
  if (CNT_W < 1) begin : g_invalid_cnt_w
  end
`endif

endmodule

// File: tb/tb_boolean.sv
// Self-checking bench for boolean: table vectors, hand sequences and random stimulus.
// Instances: default table, 8'h01, 8'hFF, and default table with a 2-bit counter.
module tb_boolean;

  logic clk = 1'b0;
  logic reset;
  logic a, b, c;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  boolean_if #(.CNT_W(8)) bus0 ();
  boolean_if #(.CNT_W(8)) bus1 ();
  boolean_if #(.CNT_W(8)) bus2 ();
  boolean_if #(.CNT_W(2)) bus3 ();

  boolean #(.TRUTH_TABLE(8'h8C), .CNT_W(8)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  boolean #(.TRUTH_TABLE(8'h01), .CNT_W(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  boolean #(.TRUTH_TABLE(8'hFF), .CNT_W(8)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
  boolean #(.TRUTH_TABLE(8'h8C), .CNT_W(2)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  assign bus0.A = a; assign bus0.B = b; assign bus0.C = c;
  assign bus1.A = a; assign bus1.B = b; assign bus1.C = c;
  assign bus2.A = a; assign bus2.B = b; assign bus2.C = c;
  assign bus3.A = a; assign bus3.B = b; assign bus3.C = c;

  logic f_o[4];
  logic fq_o[4];
  logic rise_o[4];
  assign f_o[0] = bus0.F; assign fq_o[0] = bus0.F_q; assign rise_o[0] = bus0.F_rise;
  assign f_o[1] = bus1.F; assign fq_o[1] = bus1.F_q; assign rise_o[1] = bus1.F_rise;
  assign f_o[2] = bus2.F; assign fq_o[2] = bus2.F_q; assign rise_o[2] = bus2.F_rise;
  assign f_o[3] = bus3.F; assign fq_o[3] = bus3.F_q; assign rise_o[3] = bus3.F_rise;

`ifdef BOOLEAN_TOGGLE_CNT_EN
  logic [7:0] cnt_o[4];
  assign cnt_o[0] = bus0.toggle_cnt;
  assign cnt_o[1] = bus1.toggle_cnt;
  assign cnt_o[2] = bus2.toggle_cnt;
  assign cnt_o[3] = {6'd0, bus3.toggle_cnt};
`endif

  // Reference model state
  logic exp_fq[4];
  logic exp_rise[4];
  int   exp_cnt[4];
  int   cnt_mod[4] = '{256, 256, 256, 4};

  typedef struct {
    logic [2:0] abc;
    logic       f_def;
    logic       f_01;
    logic       f_ff;
  } vec_t;

  vec_t vecs[8];

  // Function each instance implements, written from its description
  function automatic logic ref_f(input int k, input logic [2:0] v);
    logic fa, fb, fc;
    fa = v[2]; fb = v[1]; fc = v[0];
    case (k)
      1:       return (v == 3'b000);
      2:       return 1'b1;
      default: return fb & (~fa | fc);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      exp_fq[k]   = 1'b0;
      exp_rise[k] = 1'b0;
      exp_cnt[k]  = 0;
    end
  endtask

  task automatic check_comb(input string tag);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_F%0d", tag, k), {31'd0, f_o[k]}, {31'd0, ref_f(k, {a, b, c})});
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_Fq%0d", tag, k), {31'd0, fq_o[k]}, {31'd0, exp_fq[k]});
      chk($sformatf("%s_Frise%0d", tag, k), {31'd0, rise_o[k]}, {31'd0, exp_rise[k]});
`ifdef BOOLEAN_TOGGLE_CNT_EN
      chk($sformatf("%s_cnt%0d", tag, k), {24'd0, cnt_o[k]}, exp_cnt[k]);
`endif
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge
  task automatic cycle(input logic [2:0] v);
    logic f;
    {a, b, c} = v;
    #1;
    check_comb("comb");
    check_regs("pre");
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      f = ref_f(k, v);
      exp_rise[k] = f & ~exp_fq[k];
      if (f != exp_fq[k]) exp_cnt[k] = (exp_cnt[k] + 1) % cnt_mod[k];
      exp_fq[k] = f;
    end
    #1;
    check_regs("post");
    @(negedge clk);
  endtask

  // Reset pulse between edges; returns at a falling edge with reset released
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_regs(tag);
    check_comb(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int seq[5];
    vecs[0] = '{3'b000, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{3'b001, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{3'b010, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{3'b011, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{3'b100, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{3'b101, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{3'b110, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{3'b111, 1'b1, 1'b0, 1'b1};

    // Combinational checks while registers are held in reset
    reset = 1'b1;
    model_reset();
    {a, b, c} = 3'b011;
    #5;
    chk("comb_011", {31'd0, f_o[0]}, 32'd1);
    check_regs("rst");
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = vecs[i].abc;
      #1;
      chk($sformatf("tbl%0d_def", i), {31'd0, f_o[0]}, {31'd0, vecs[i].f_def});
      chk($sformatf("tbl%0d_01", i), {31'd0, f_o[1]}, {31'd0, vecs[i].f_01});
      chk($sformatf("tbl%0d_ff", i), {31'd0, f_o[2]}, {31'd0, vecs[i].f_ff});
      chk($sformatf("tbl%0d_def3", i), {31'd0, f_o[3]}, {31'd0, vecs[i].f_def});
      chk($sformatf("tbl%0d_fq_rst", i), {31'd0, fq_o[2]}, 32'd0);
    end

    @(negedge clk);
    {a, b, c} = 3'b000;
    reset = 1'b0;

    // Registered latency and single-cycle pulse
    cycle(3'b000);
    chk("lat_fq_before", {31'd0, fq_o[0]}, 32'd0);
    cycle(3'b010);
    chk("lat_fq_after", {31'd0, fq_o[0]}, 32'd1);
    chk("lat_rise", {31'd0, rise_o[0]}, 32'd1);
    cycle(3'b010);
    chk("lat_rise_gone", {31'd0, rise_o[0]}, 32'd0);

    // Async reset with F_q high
    reset_pulse("async");
    chk("async_fq", {31'd0, fq_o[0]}, 32'd0);
    chk("async_F", {31'd0, f_o[0]}, 32'd1);

    // Held input: one pulse only
    cycle(3'b000);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(3'b111);
      n += int'(rise_o[0]);
    end
    chk("held_pulses", n, 32'd1);
    chk("held_fq", {31'd0, fq_o[0]}, 32'd1);

`ifdef BOOLEAN_TOGGLE_CNT_EN
    // 2-bit counter wraps
    {a, b, c} = 3'b000;
    reset_pulse("cnt_rst");
    seq = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      cycle((i % 2 == 0) ? 3'b011 : 3'b000);
      chk($sformatf("cnt_seq%0d", i), {24'd0, cnt_o[3]}, seq[i]);
    end
`endif

    // Random stimulus with occasional mid-run reset
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) reset_pulse("rnd_rst");
      else cycle(3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boolean.md
Name: boolean

Overview:
- 3-input Boolean function unit.
- Evaluates a truth-table-defined function F of inputs A, B, C combinationally.
- Also provides a registered copy of F and a rising-edge pulse for synchronous consumers.
- Used as a leaf logic block in basic-logic-circuit designs; the default function is F = B & (~A | C).

Parameters:
- TRUTH_TABLE, 8'h8C, bit i gives F for index i = {A,B,C} (A is MSB); default is minterms 2, 3, 7.
- CNT_W, 8, width of the optional toggle counter.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- reset  input  1  asynchronous, active-high reset.
- A  input  1  function input, MSB of the table index.
- B  input  1  function input, middle bit of the table index.
- C  input  1  function input, LSB of the table index.
- F  output  1  combinational result, TRUTH_TABLE[{A,B,C}].
- F_q  output  1  F registered on the rising edge of clk.
- F_rise  output  1  one-cycle pulse when F_q goes 0->1.
- toggle_cnt  output  CNT_W  number of F_q transitions (only with BOOLEAN_TOGGLE_CNT_EN).

Behaviour:
- One clock (clk); reset is asynchronous and active-high (reset).
- F is purely combinational, with zero latency, and is independent of clk and reset.
  - Default table gives: F=1 only for {A,B,C} = 010, 011, 111; F=0 for 000, 001, 100, 101, 110.
  - Example: A=0, B=1, C=1 -> F=1.
  - F settles within the same delta/time step as an input change.
- F_q:
  - Reset value 0; asserting reset clears it immediately, without waiting for a clock edge.
  - Otherwise F_q <= F at each rising clk edge, giving one cycle of latency.
- F_rise:
  - Reset value 0.
  - Registered: F_rise <= F & ~F_q at each rising edge, so it is high exactly for the cycle in which F_q first becomes 1.
  - A held-high F produces a single pulse only.
  - F_rise is never high in the first cycle after reset deassertion unless F=1 at that first edge.
- Reset mid-operation: F_q, F_rise and toggle_cnt clear asynchronously; F keeps tracking its inputs.
- Unknown inputs (X/Z) propagate as X on F; they are not masked.
- Any TRUTH_TABLE value is legal: 8'h00 gives constant 0, and 8'hFF gives constant 1 with F_rise pulsing once after reset.

Optional Feature:
- Macro: BOOLEAN_TOGGLE_CNT_EN.
- Defined:
  - toggle_cnt is present; reset value 0.
  - Increments by 1 on every rising edge where F != F_q.
  - Wraps modulo 2^CNT_W, so all-ones rolls to 0 with no saturation or flag.
- Undefined: the toggle_cnt port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package boolean_pkg holds DEFAULT_TRUTH_TABLE = 8'h8C and DEFAULT_CNT_W = 8.
- One natural sub-module: boolean_lut3, the combinational 8-entry lookup producing F.
- The top level adds the registers, the edge detector and the optional counter.

Test Plan:
- Combinational: A=0, B=1, C=1, wait 5 ns -> F=1; sweep all 8 input combinations -> F matches 8'h8C bit by bit.
- Registered latency: reset released, A=0, B=1, C=0 -> F_q=0 before the next rising edge and 1 after it; F_rise=1 for exactly one cycle.
- Async reset: with F_q=1, assert reset between edges -> F_q=0 and F_rise=0 immediately; F is unaffected.
- Held input: keep {A,B,C}=111 for 10 cycles -> F_rise pulses once and F_q stays 1.
- Parameter override: TRUTH_TABLE=8'h01 -> F=1 only for 000; TRUTH_TABLE=8'hFF -> F constantly 1.
- With BOOLEAN_TOGGLE_CNT_EN and CNT_W=2: toggle inputs between 011 and 000 every cycle for 5 transitions -> toggle_cnt sequence 1, 2, 3, 0, 1.
